// File: rtl/axil_pkt_sorter.sv
// axil_pkt_sorter: AXI4-Lite write slave that classifies data words by header byte into valid/invalid FWFT FIFOs
//   i_clk, i_rst_n (async active-low)
//   AXI-Lite write: i_awaddr/i_awvalid/o_awready, i_wdata/i_wvalid/o_wready, o_bresp/o_bvalid/i_bready
//   valid FIFO:   i_val_rd_en,  o_val_rd_data,  o_val_full,  o_val_empty,  o_val_count
//   invalid FIFO: i_ival_rd_en, o_ival_rd_data, o_ival_full, o_ival_empty, o_ival_count
//   o_magic: current magic byte; o_drop_cnt: saturating count of full-drops
//   Define SORTER_DROP_CNT_EN to implement the drop counter (otherwise it reads 0).
//   Registers: 0x00 CTRL (bits[7:0] magic, bit 8 flush), 0x04 DATA; other addresses -> SLVERR.
module axil_pkt_sorter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH = 16,
  parameter logic [7:0] MAGIC = 8'hA5,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_awaddr,
  input  logic              i_awvalid,
  output logic              o_awready,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_wvalid,
  output logic              o_wready,
  output logic [1:0]        o_bresp,
  output logic              o_bvalid,
  input  logic              i_bready,
  input  logic              i_val_rd_en,
  output logic [DATA_W-1:0] o_val_rd_data,
  output logic              o_val_full,
  output logic              o_val_empty,
  output logic [CNT_W-1:0]  o_val_count,
  input  logic              i_ival_rd_en,
  output logic [DATA_W-1:0] o_ival_rd_data,
  output logic              o_ival_full,
  output logic              o_ival_empty,
  output logic [CNT_W-1:0]  o_ival_count,
  output logic [7:0]        o_magic,
  output logic [15:0]       o_drop_cnt
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [2:0] {S_IDLE, S_HAVE_A, S_HAVE_W, S_COMMIT, S_RESP} state_t;
  state_t r_state, w_next;
  logic r_awready, r_wready, r_bvalid;
  logic [1:0] r_bresp;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [7:0] r_magic;
  logic w_aw_hs, w_w_hs, w_commit, w_is_ctrl, w_is_data, w_hdr_ok, w_tgt_full, w_flush;
  logic [1:0] w_push, w_full, w_empty, w_rd_en;
  logic [DATA_W-1:0] w_rd_data [2];
  logic [CNT_W-1:0] w_count [2];
  assign w_aw_hs = i_awvalid && r_awready;
  assign w_w_hs = i_wvalid && r_wready;
  assign w_commit = r_state == S_COMMIT;
  assign w_is_ctrl = r_addr == ADDR_W'(0);
  assign w_is_data = r_addr == ADDR_W'(4);
  assign w_hdr_ok = r_data[DATA_W-1 -: 8] == r_magic;
  assign w_tgt_full = w_hdr_ok ? w_full[0] : w_full[1];
  assign w_flush = w_commit && w_is_ctrl && r_data[8];
  assign w_push[0] = w_commit && w_is_data && w_hdr_ok && !w_full[0];
  assign w_push[1] = w_commit && w_is_data && !w_hdr_ok && !w_full[1];
  assign w_rd_en = {i_ival_rd_en, i_val_rd_en};
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = (w_aw_hs && w_w_hs) ? S_COMMIT : w_aw_hs ? S_HAVE_A : w_w_hs ? S_HAVE_W : S_IDLE;
      S_HAVE_A: w_next = w_w_hs ? S_COMMIT : S_HAVE_A;
      S_HAVE_W: w_next = w_aw_hs ? S_COMMIT : S_HAVE_W;
      S_COMMIT: w_next = S_RESP;
      S_RESP:   w_next = (r_bvalid && i_bready) ? S_IDLE : S_RESP;
      default:  w_next = S_IDLE;
    endcase
  end
  // Handshake outputs are registered from the next state so they stay low until the first edge after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_awready <= 1'b0;
      r_wready <= 1'b0;
      r_bvalid <= 1'b0;
      r_bresp <= 2'b00;
      r_addr <= '0;
      r_data <= '0;
      r_magic <= MAGIC;
    end else begin
      r_state <= w_next;
      r_awready <= (w_next == S_IDLE) || (w_next == S_HAVE_W);
      r_wready <= (w_next == S_IDLE) || (w_next == S_HAVE_A);
      r_bvalid <= w_next == S_RESP;
      if (w_aw_hs) r_addr <= i_awaddr;
      if (w_w_hs) r_data <= i_wdata;
      if (w_commit) r_bresp <= (w_is_ctrl || (w_is_data && !w_tgt_full)) ? 2'b00 : 2'b10;
      if (w_commit && w_is_ctrl) r_magic <= r_data[7:0];
    end
  end
  for (genvar f = 0; f < 2; f++) begin : g_fifo
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wp, r_rp;
    logic [CNT_W-1:0] r_cnt;
    logic w_pop;
    assign w_pop = w_rd_en[f] && !w_empty[f];
    assign w_full[f] = r_cnt == CNT_W'(DEPTH);
    assign w_empty[f] = r_cnt == '0;
    assign w_rd_data[f] = r_mem[r_rp];
    assign w_count[f] = r_cnt;
    // Flush has priority over any same-cycle pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_wp <= '0;
        r_rp <= '0;
        r_cnt <= '0;
      end else if (w_flush) begin
        r_wp <= '0;
        r_rp <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push[f]) r_wp <= r_wp + PW'(1);
        if (w_pop) r_rp <= r_rp + PW'(1);
        r_cnt <= r_cnt + CNT_W'(w_push[f]) - CNT_W'(w_pop);
      end
    end
    always_ff @(posedge i_clk) begin
      if (w_push[f]) r_mem[r_wp] <= r_data;
    end
  end
`ifdef SORTER_DROP_CNT_EN
  logic [15:0] r_drop;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_drop <= '0;
    else if (w_commit && w_is_data && w_tgt_full && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
  end
  assign o_drop_cnt = r_drop;
`else
  assign o_drop_cnt = '0;
`endif
  assign o_awready = r_awready;
  assign o_wready = r_wready;
  assign o_bvalid = r_bvalid;
  assign o_bresp = r_bresp;
  assign o_magic = r_magic;
  assign o_val_rd_data = w_rd_data[0];
  assign o_val_full = w_full[0];
  assign o_val_empty = w_empty[0];
  assign o_val_count = w_count[0];
  assign o_ival_rd_data = w_rd_data[1];
  assign o_ival_full = w_full[1];
  assign o_ival_empty = w_empty[1];
  assign o_ival_count = w_count[1];
endmodule

// File: tb/tb_axil_pkt_sorter.sv
// tb_axil_pkt_sorter: directed self-checking bench for axil_pkt_sorter
module tb_axil_pkt_sorter;
`ifdef SORTER_DROP_CNT_EN
  localparam int DROP_EN = 1;
`else
  localparam int DROP_EN = 0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] awaddr = '0;
  logic awvalid = 1'b0;
  logic [31:0] wdata = '0;
  logic wvalid = 1'b0;
  logic bready = 1'b1;
  logic val_rd_en = 1'b0;
  logic ival_rd_en = 1'b0;
  logic o_awready, o_wready, o_bvalid;
  logic [1:0] o_bresp;
  logic [31:0] o_val_rd_data, o_ival_rd_data;
  logic o_val_full, o_val_empty, o_ival_full, o_ival_empty;
  logic [4:0] o_val_count, o_ival_count;
  logic [7:0] o_magic;
  logic [15:0] o_drop_cnt;
  int n_tests = 0;
  int n_fail = 0;
  logic [1:0] resp;
  axil_pkt_sorter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_awaddr(awaddr), .i_awvalid(awvalid), .o_awready(o_awready),
    .i_wdata(wdata), .i_wvalid(wvalid), .o_wready(o_wready),
    .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(bready),
    .i_val_rd_en(val_rd_en), .o_val_rd_data(o_val_rd_data), .o_val_full(o_val_full),
    .o_val_empty(o_val_empty), .o_val_count(o_val_count),
    .i_ival_rd_en(ival_rd_en), .o_ival_rd_data(o_ival_rd_data), .o_ival_full(o_ival_full),
    .o_ival_empty(o_ival_empty), .o_ival_count(o_ival_count),
    .o_magic(o_magic), .o_drop_cnt(o_drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Present AW and W together; returns on the negedge after the final handshake (DUT in COMMIT).
  task automatic send(input logic [31:0] a, input logic [31:0] d);
    int n;
    logic ah, wh;
    n = 0;
    @(negedge clk);
    awaddr = a;
    awvalid = 1'b1;
    wdata = d;
    wvalid = 1'b1;
    while ((awvalid || wvalid) && n < 20) begin
      ah = awvalid && o_awready;
      wh = wvalid && o_wready;
      @(negedge clk);
      if (ah) awvalid = 1'b0;
      if (wh) wvalid = 1'b0;
      n++;
    end
    chk("hs_done", {63'd0, !(awvalid || wvalid)}, 64'd1);
    awvalid = 1'b0;
    wvalid = 1'b0;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, output logic [1:0] r);
    send(a, d);
    chk("bv_commit", {63'd0, o_bvalid}, 64'd0);
    @(negedge clk);
    chk("bv_lat", {63'd0, o_bvalid}, 64'd1);
    r = o_bresp;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_awready", {63'd0, o_awready}, 64'd0);
    chk("rst_wready", {63'd0, o_wready}, 64'd0);
    chk("rst_bvalid", {63'd0, o_bvalid}, 64'd0);
    chk("rst_bresp", {62'd0, o_bresp}, 64'd0);
    chk("rst_val_empty", {63'd0, o_val_empty}, 64'd1);
    chk("rst_ival_empty", {63'd0, o_ival_empty}, 64'd1);
    chk("rst_val_full", {63'd0, o_val_full}, 64'd0);
    chk("rst_counts", {54'd0, o_val_count, o_ival_count}, 64'd0);
    chk("rst_magic", {56'd0, o_magic}, 64'hA5);
    chk("rst_drop", {48'd0, o_drop_cnt}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rdy_before_clk", {63'd0, o_awready}, 64'd0);
    @(negedge clk);
    chk("rdy_rise", {62'd0, o_awready, o_wready}, 64'd3);
    // basic valid write
    wr(32'h4, 32'hA5001234, resp);
    chk("t1_resp", {62'd0, resp}, 64'd0);
    chk("t1_vcount", {59'd0, o_val_count}, 64'd1);
    chk("t1_vdata", {32'd0, o_val_rd_data}, 64'hA5001234);
    chk("t1_ival_empty", {63'd0, o_ival_empty}, 64'd1);
    // staggered AW then W
    @(negedge clk);
    awaddr = 32'h4;
    awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("t2_awready_a", {63'd0, o_awready}, 64'd0);
    repeat (2) begin
      @(negedge clk);
      chk("t2_awready_b", {63'd0, o_awready}, 64'd0);
    end
    wdata = 32'h11223344;
    wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    chk("t2_awready_c", {63'd0, o_awready}, 64'd0);
    chk("t2_bv_commit", {63'd0, o_bvalid}, 64'd0);
    @(negedge clk);
    chk("t2_bvalid", {63'd0, o_bvalid}, 64'd1);
    chk("t2_resp", {62'd0, o_bresp}, 64'd0);
    chk("t2_icount", {59'd0, o_ival_count}, 64'd1);
    chk("t2_idata", {32'd0, o_ival_rd_data}, 64'h11223344);
    // runtime magic
    wr(32'h0, 32'h0000003C, resp);
    chk("t3_ctrl_resp", {62'd0, resp}, 64'd0);
    chk("t3_magic", {56'd0, o_magic}, 64'h3C);
    wr(32'h4, 32'h3C000001, resp);
    wr(32'h4, 32'hA5000002, resp);
    chk("t3_vcount", {59'd0, o_val_count}, 64'd2);
    chk("t3_icount", {59'd0, o_ival_count}, 64'd2);
    chk("t3_vhead", {32'd0, o_val_rd_data}, 64'hA5001234);
    wr(32'h0, 32'h000001A5, resp);
    chk("t3_flush_magic", {56'd0, o_magic}, 64'hA5);
    chk("t3_flush_cnt", {54'd0, o_val_count, o_ival_count}, 64'd0);
    chk("t3_flush_empty", {62'd0, o_val_empty, o_ival_empty}, 64'd3);
    // pop on empty is ignored
    @(negedge clk);
    val_rd_en = 1'b1;
    @(negedge clk);
    val_rd_en = 1'b0;
    chk("pop_empty", {59'd0, o_val_count}, 64'd0);
    // offset pointers so the fill wraps the buffer
    wr(32'h4, 32'hA5FFFFFF, resp);
    val_rd_en = 1'b1;
    @(negedge clk);
    val_rd_en = 1'b0;
    chk("offset_empty", {63'd0, o_val_empty}, 64'd1);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 17; i++) begin
        wr(32'h4, 32'hA5000000 | (p << 12) | i, resp);
        if (i == 14) chk("fill_not_full", {63'd0, o_val_full}, 64'd0);
        if (i == 15) begin
          chk("fill_full", {63'd0, o_val_full}, 64'd1);
          chk("fill_count", {59'd0, o_val_count}, 64'd16);
          chk("fill_resp", {62'd0, resp}, 64'd0);
        end
      end
      chk("drop_resp", {62'd0, resp}, 64'd2);
      chk("drop_cnt", {48'd0, o_drop_cnt}, 64'(DROP_EN * (p + 1)));
      chk("drop_count", {59'd0, o_val_count}, 64'd16);
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
        chk("pop_data", {32'd0, o_val_rd_data}, 64'(32'hA5000000 | (p << 12) | i));
        val_rd_en = 1'b1;
        @(negedge clk);
      end
      val_rd_en = 1'b0;
      chk("pop_empty_end", {63'd0, o_val_empty}, 64'd1);
      chk("pop_count_end", {59'd0, o_val_count}, 64'd0);
    end
    // BREADY backpressure on a bad address
    bready = 1'b0;
    send(32'h8, 32'hA5000000);
    @(negedge clk);
    repeat (4) begin
      chk("bp_bvalid", {63'd0, o_bvalid}, 64'd1);
      chk("bp_bresp", {62'd0, o_bresp}, 64'd2);
      chk("bp_ready", {62'd0, o_awready, o_wready}, 64'd0);
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    chk("bp_release", {63'd0, o_bvalid}, 64'd0);
    chk("bp_no_push", {54'd0, o_val_count, o_ival_count}, 64'd0);
    // flush wins over a same-cycle pop
    for (int i = 0; i < 3; i++) wr(32'h4, 32'hA5000100 + i, resp);
    chk("fl_pre", {59'd0, o_val_count}, 64'd3);
    send(32'h0, 32'h000001A5);
    val_rd_en = 1'b1;
    @(negedge clk);
    val_rd_en = 1'b0;
    chk("fl_count", {59'd0, o_val_count}, 64'd0);
    chk("fl_empty", {63'd0, o_val_empty}, 64'd1);
    chk("fl_resp", {61'd0, o_bvalid, o_bresp}, 64'd4);
    // reset during a transaction aborts it
    wr(32'h4, 32'hA5000200, resp);
    chk("rm_pre", {59'd0, o_val_count}, 64'd1);
    send(32'h4, 32'h77000000);
    rst_n = 1'b0;
    #1;
    chk("rm_counts", {54'd0, o_val_count, o_ival_count}, 64'd0);
    chk("rm_bvalid", {63'd0, o_bvalid}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rm_no_bvalid", {63'd0, o_bvalid}, 64'd0);
      chk("rm_no_push", {59'd0, o_ival_count}, 64'd0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
